seq_array_multiplier: RTL and testbench

Parametrised, clocked successor to the team's 16-bit combinational array multiplier. It accumulates ROWS_PER_CYCLE partial-product rows per clock, so width and area/latency are tunable. Operands enter and the product leaves through valid/ready handshakes, so the block sits on datapath streams between producer and consumer stages. Signed operation is an optional compile-time feature.

---
 rtl/seq_array_multiplier.sv | 155 +++++++++++++++
 tb/tb_seq_array_multiplier.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_array_multiplier.sv
`default_nettype none
// ============================================================================
// seq_array_multiplier : sequential array multiplier, ROWS_PER_CYCLE rows/clk,
//                        valid/ready on both sides; SIGNED_MUL_EN adds op_signed
// Revision: 1.0
// ============================================================================
module seq_array_multiplier #(
    parameter int WIDTH          = 16,
    parameter int ROWS_PER_CYCLE = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef SIGNED_MUL_EN
    input  logic                 op_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int c_N     = WIDTH / ROWS_PER_CYCLE;
    localparam int c_CNT_W = (c_N > 1) ? $clog2(c_N) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(c_N - 1);

    generate
        if ((WIDTH < 2) || (WIDTH > 64)) begin : g_bad_width
            $error("seq_array_multiplier: WIDTH must be in 2..64");
        end
        if ((ROWS_PER_CYCLE < 1) || ((WIDTH % ROWS_PER_CYCLE) != 0)) begin : g_bad_rows
            $error("seq_array_multiplier: ROWS_PER_CYCLE must divide WIDTH");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2*WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]       r_b;
    logic [2*WIDTH-1:0]     r_acc;
    logic [2*WIDTH-1:0]     r_product;
    logic [c_CNT_W-1:0]     r_cnt;
    logic                   r_out_valid;
    logic                   w_last;
    logic                   w_neg_last;
    logic [2*WIDTH-1:0]     w_a_ext;
    logic [2*WIDTH-1:0]     w_row;
    logic [2*WIDTH-1:0]     w_acc_next;

    assign w_last = (r_cnt == c_LAST);

`ifdef SIGNED_MUL_EN
    logic r_signed;
    assign w_a_ext    = op_signed ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    assign w_neg_last = r_signed & w_last;
`else
    assign w_a_ext    = {{WIDTH{1'b0}}, a};
    assign w_neg_last = 1'b0;
`endif

    // r_a / r_b are pre-shifted each cycle, so row k of this cycle is always
    // r_b[k] * (r_a << k); the top row of the last cycle is b's sign bit.
    always_comb begin
        w_acc_next = r_acc;
        w_row      = '0;
        for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            w_row = r_b[k] ? (r_a << k) : '0;
            if (w_neg_last && (k == ROWS_PER_CYCLE - 1)) begin
                w_acc_next = w_acc_next - w_row;
            end else begin
                w_acc_next = w_acc_next + w_row;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (in_valid)                  w_state_next = ST_ACCUM;
            ST_ACCUM: if (w_last)                    w_state_next = ST_DONE;
            ST_DONE:  if (r_out_valid && out_ready)  w_state_next = ST_IDLE;
            default:                                 w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_product   <= '0;
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
`ifdef SIGNED_MUL_EN
            r_signed    <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= w_a_ext;
                        r_b   <= b;
                        r_acc <= '0;
                        r_cnt <= '0;
`ifdef SIGNED_MUL_EN
                        r_signed <= op_signed;
`endif
                    end
                end
                ST_ACCUM: begin
                    r_acc <= w_acc_next;
                    r_a   <= r_a << ROWS_PER_CYCLE;
                    r_b   <= r_b >> ROWS_PER_CYCLE;
                    r_cnt <= r_cnt + c_CNT_W'(1);
                end
                ST_DONE: begin
                    // First DONE cycle publishes the result; product then holds.
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                        r_product   <= r_acc;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign out_valid = r_out_valid;
    assign product   = r_product;

endmodule
`default_nettype wire

// File: tb/tb_seq_array_multiplier.sv
`default_nettype none
// Testbench for seq_array_multiplier: scoreboard of expected products plus
// per-scenario tasks for latency, backpressure, reset and parameter sweep.
module tb_seq_array_multiplier;

    localparam int W   = 16;
    localparam int RPC = 4;
    localparam int LAT = W / RPC + 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic             in_valid, in_ready, out_valid, out_ready, busy, op_s;
    logic [W-1:0]     a, b;
    logic [2*W-1:0]   product;

    logic             iv8, ir8, ov8, or8, busy8;
    logic [7:0]       a8, b8;
    logic [15:0]      p8;
    logic             iv32, ir32, ov32, or32, busy32;
    logic [31:0]      a32, b32;
    logic [63:0]      p32;

    int tests = 0;
    int fails = 0;
    logic [2*W-1:0] sb_q[$];
    logic [2*W-1:0] sb_exp;

    seq_array_multiplier #(.WIDTH(W), .ROWS_PER_CYCLE(RPC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b),
`ifdef SIGNED_MUL_EN
        .op_signed(op_s),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy)
    );

    seq_array_multiplier #(.WIDTH(8), .ROWS_PER_CYCLE(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .a(a8), .b(b8),
`ifdef SIGNED_MUL_EN
        .op_signed(1'b0),
`endif
        .out_valid(ov8), .out_ready(or8), .product(p8), .busy(busy8)
    );

    seq_array_multiplier #(.WIDTH(32), .ROWS_PER_CYCLE(1)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32),
        .a(a32), .b(b32),
`ifdef SIGNED_MUL_EN
        .op_signed(1'b0),
`endif
        .out_valid(ov32), .out_ready(or32), .product(p32), .busy(busy32)
    );

    // Scoreboard: compare every output handshake of the main DUT.
    always @(negedge clk) begin
        if (rst_n && out_valid === 1'b1 && out_ready === 1'b1) begin
            tests++;
            if (sb_q.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: product %h emitted, nothing expected", product);
            end else begin
                sb_exp = sb_q.pop_front();
                if (product !== sb_exp) begin
                    fails++;
                    $display("FAIL sb_product: got %h expected %h", product, sb_exp);
                end
            end
        end
    end

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic sgn,
                          input logic [2*W-1:0] exp_p, input int bp, input string nm);
        int lat;
        a = ta; b = tbv; op_s = sgn; in_valid = 1'b1; out_ready = 1'b0;
        sb_q.push_back(exp_p);
        @(posedge clk); #1;
        in_valid = 1'bx; a = 'x; b = 'x; op_s = 1'bx;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat != LAT) begin
            fails++;
            $display("FAIL %s_latency: got %0d edges expected %0d", nm, lat, LAT);
        end
        for (int i = 0; i < bp; i++) begin
            tests++;
            if (product !== exp_p || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL %s_hold: product %h ov %b ir %b busy %b expected %h 1 0 1",
                         nm, product, out_valid, in_ready, busy, exp_p);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL %s_return: ir %b ov %b busy %b expected 1 0 0", nm, in_ready, out_valid, busy);
        end
        tests++;
        if (product !== exp_p) begin
            fails++;
            $display("FAIL %s_product_hold: got %h expected %h", nm, product, exp_p);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op_s = 1'b0;
        iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0;
        iv32 = 1'b0; or32 = 1'b0; a32 = '0; b32 = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            fails++;
            $display("FAIL reset_state: ir %b ov %b busy %b product %h expected 1 0 0 0",
                     in_ready, out_valid, busy, product);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        run_op(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001, 0, "max");
        run_op(16'h1234, 16'h0000, 1'b0, 32'h00000000, 0, "zero_b");
        run_op(16'h0000, 16'hABCD, 1'b0, 32'h00000000, 0, "zero_a");
    endtask

    task automatic test_backpressure();
        run_op(16'h00FF, 16'h0101, 1'b0, 32'h0000FFFF, 10, "bp");
    endtask

    task automatic test_back_to_back();
        int n;
        a = 16'h0011; b = 16'h0022; in_valid = 1'b1; out_ready = 1'b1;
        sb_q.push_back(32'h00000242);
        @(posedge clk); #1;
        a = 16'h0100; b = 16'h0003;
        sb_q.push_back(32'h00000300);
        n = 0;
        while (in_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        tests++;
        if (n != LAT + 1) begin
            fails++;
            $display("FAIL b2b_ready_return: got %0d edges expected %0d", n, LAT + 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        tests++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL b2b_second_accept: ir %b busy %b expected 0 1", in_ready, busy);
        end
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL b2b_drain: got %0d pending expected 0", sb_q.size());
        end
    endtask

    task automatic test_reset_mid_accum();
        int bad;
        a = 16'h0003; b = 16'h0005; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        tests++;
        if (out_valid !== 1'b0 || product !== '0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_state: ov %b product %h ir %b busy %b expected 0 0 1 0",
                     out_valid, product, in_ready, busy);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
            @(posedge clk); #1;
        end
        out_ready = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mid_reset_quiet: got %0d active cycles expected 0", bad);
        end
        run_op(16'h0003, 16'h0005, 1'b0, 32'h0000000F, 0, "post_reset");
    endtask

    task automatic test_param_sweep();
        int lat;
        a8 = 8'hFF; b8 = 8'hFF; iv8 = 1'b1; or8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0;
        while (ov8 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat != 2 || p8 !== 16'hFE01) begin
            fails++;
            $display("FAIL w8_op: latency %0d product %h expected 2 fe01", lat, p8);
        end
        @(posedge clk); #1;
        tests++;
        if (ir8 !== 1'b1 || ov8 !== 1'b0) begin
            fails++;
            $display("FAIL w8_return: ir %b ov %b expected 1 0", ir8, ov8);
        end

        a32 = 32'hFFFFFFFF; b32 = 32'h00000002; iv32 = 1'b1; or32 = 1'b1;
        @(posedge clk); #1;
        iv32 = 1'b0;
        lat = 0;
        while (ov32 !== 1'b1 && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        tests++;
        if (lat != 33 || p32 !== 64'h00000001FFFFFFFE) begin
            fails++;
            $display("FAIL w32_op: latency %0d product %h expected 33 00000001fffffffe", lat, p32);
        end
        @(posedge clk); #1;
        tests++;
        if (ir32 !== 1'b1 || ov32 !== 1'b0) begin
            fails++;
            $display("FAIL w32_return: ir %b ov %b expected 1 0", ir32, ov32);
        end
    endtask

`ifdef SIGNED_MUL_EN
    task automatic test_signed();
        run_op(16'h8000, 16'h0002, 1'b1, 32'hFFFF0000, 0, "s_min_x2");
        run_op(16'hFFFF, 16'hFFFF, 1'b1, 32'h00000001, 0, "s_m1_m1");
        run_op(16'h8000, 16'h0002, 1'b0, 32'h00010000, 0, "u_8000_x2");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_accum();
        test_param_sweep();
`ifdef SIGNED_MUL_EN
        test_signed();
`endif
        @(posedge clk); #1;
        tests++;
        if (sb_q.size() != 0) begin
            fails++;
            $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
